// File: rtl/sysbus_pkg.sv
// sysbus_pkg: shared Sysbus constants, tag fields and arbiter state encoding
package sysbus_pkg;

    localparam int SYSBUS_DATA_W     = 64;
    localparam int SYSBUS_TAG_W      = 13;
    localparam int SYSBUS_LINE_BYTES = 64;
    localparam int SYSBUS_BEATS      = SYSBUS_LINE_BYTES * 8 / SYSBUS_DATA_W;

    // tag = {rw, type, id}
    localparam int SYSBUS_RW_W   = 1;
    localparam int SYSBUS_TYPE_W = 4;
    localparam int SYSBUS_ID_W   = 8;

    localparam logic                     SYSBUS_WRITE  = 1'b0;
    localparam logic                     SYSBUS_READ   = 1'b1;
    localparam logic [SYSBUS_TYPE_W-1:0] SYSBUS_MEMORY = 4'h1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, one-hot grant while advance is high
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt
);

    // r_ptr names the port favoured on the next tie; it flips away from each winner
    logic r_ptr;

    // single requester always wins, a tie goes to the favoured port
    always_comb begin
        o_gnt[0] = i_advance & i_req[0] & (~i_req[1] | ~r_ptr);
        o_gnt[1] = i_advance & i_req[1] & (~i_req[0] | r_ptr);
    end

    // move the preference to the other port whenever a grant is issued
    always_ff @(posedge clk) begin
        if (reset)
            r_ptr <= 1'b0;
        else if (|o_gnt)
            r_ptr <= o_gnt[0];
    end

endmodule

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: shares one Sysbus master port between I-side (0) and D-side (1) line clients
module sysbus_arbiter
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = SYSBUS_DATA_W,
    parameter int BUS_TAG_WIDTH  = SYSBUS_TAG_W,
    parameter int LINE_BYTES     = SYSBUS_LINE_BYTES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [1:0]                     c_req_valid,
    input  logic [1:0]                     c_req_write,
    input  logic [1:0][63:0]               c_req_addr,
    input  logic [1:0][LINE_BYTES*8-1:0]   c_wline,
    output logic [1:0]                     c_gnt,
    output logic [1:0]                     c_resp_valid,
    output logic [BUS_DATA_WIDTH-1:0]      c_resp_data,
    output logic                           c_resp_last,
    output logic [1:0]                     c_done,
    output logic                           bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]      bus_req,
    output logic [BUS_TAG_WIDTH-1:0]       bus_reqtag,
    input  logic                           bus_reqack,
    input  logic                           bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]      bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]       bus_resptag,
    output logic                           bus_respack
);

    localparam int BEATS    = LINE_BYTES * 8 / BUS_DATA_WIDTH;
    localparam int BEAT_W   = $clog2(BEATS);
    localparam int OFFSET_W = $clog2(LINE_BYTES);

    arb_state_t                r_state;
    logic                      r_owner;
    logic                      r_write;
    logic [63-OFFSET_W:0]      r_addr;
    logic [LINE_BYTES*8-1:0]   r_line;
    logic [BEAT_W-1:0]         r_beat;

    logic [1:0]                w_gnt;
    logic                      w_last;
    logic                      w_on_req;
    logic                      w_wr_done;
    logic [1:0]                w_owner_mask;
    logic [BUS_TAG_WIDTH-1:0]  w_tag;
    logic                      w_unused;

    // response tags and sub-line address bits carry nothing this block needs
    assign w_unused = ^{bus_resptag, c_req_addr[0][OFFSET_W-1:0], c_req_addr[1][OFFSET_W-1:0]};

    rr_arbiter2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .i_req     (c_req_valid),
        .i_advance (~reset && r_state == IDLE),
        .o_gnt     (w_gnt)
    );

    // bus and client outputs decode from state; gated by reset so a dying burst shows nothing
    always_comb begin
        w_last       = r_beat == BEAT_W'(BEATS - 1);
        w_on_req     = ~reset && (r_state == ADDR || r_state == WDATA);
        w_wr_done    = ~reset && r_state == WDATA && w_last;
        w_owner_mask = {r_owner, ~r_owner};
        w_tag        = BUS_TAG_WIDTH'({r_write ? SYSBUS_WRITE : SYSBUS_READ, SYSBUS_MEMORY, 8'h00});
        c_gnt        = w_gnt;
        bus_reqcyc   = w_on_req;
        bus_req      = !w_on_req ? '0 :
                       r_state == ADDR ? BUS_DATA_WIDTH'({r_addr, {OFFSET_W{1'b0}}}) :
                       r_line[BUS_DATA_WIDTH-1:0];
        bus_reqtag   = w_on_req ? w_tag : '0;
        bus_respack  = ~reset && r_state == RDATA && bus_respcyc;
        c_resp_valid = {2{bus_respack}} & w_owner_mask;
        c_resp_data  = bus_respack ? bus_resp : '0;
        c_resp_last  = bus_respack & w_last;
        c_done       = {2{c_resp_last | w_wr_done}} & w_owner_mask;
    end

    // transaction sequencer: latch on grant, address phase until ack, then stream the line
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_write <= 1'b0;
            r_beat  <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (|w_gnt) begin
                    r_owner <= w_gnt[1];
                    r_write <= c_req_write[w_gnt[1]];
                    r_addr  <= c_req_addr[w_gnt[1]][63:OFFSET_W];
                    r_line  <= c_wline[w_gnt[1]];
                    r_state <= ADDR;
                end
                ADDR: if (bus_reqack) begin
                    r_beat  <= '0;
                    r_state <= r_write ? WDATA : RDATA;
                end
                WDATA: begin
                    r_beat  <= r_beat + 1'b1;
                    r_line  <= r_line >> BUS_DATA_WIDTH;
                    r_state <= w_last ? IDLE : WDATA;
                end
                RDATA: if (bus_respcyc) begin
                    r_beat  <= r_beat + 1'b1;
                    r_state <= w_last ? IDLE : RDATA;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
